alu_arbiter: RTL and testbench

- Two-requester, round-robin scheduler for the shared 32-bit combinational ALU.
- Requesters are the integer execute path (port 0) and the address/branch-compare path (port 1).
- Latches the granted operands and opcode into registers driving the ALU, waits a per-opcode settle time, then captures the result and a locally computed zero flag, returning them with a DONE pulse.
- Sits between the control unit and the ALU; illegal opcodes are screened so they never reach the ALU.

---
 rtl/alu_arbiter_pkg.sv | 36 +++
 rtl/alu_arbiter_if.sv | 25 ++
 rtl/alu_arbiter_rr_arb2.sv | 15 +
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: widths, opcodes, default settle
// times and FSM state encoding.
package alu_arbiter_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ALU_OPRN_WIDTH = 6;

  localparam int DEF_SETTLE_CYCLES     = 2;
  localparam int DEF_MUL_SETTLE_CYCLES = 4;

  localparam logic [ALU_OPRN_WIDTH-1:0] OP_ADD = 6'h01;
  localparam logic [ALU_OPRN_WIDTH-1:0] OP_SUB = 6'h02;
  localparam logic [ALU_OPRN_WIDTH-1:0] OP_MUL = 6'h03;
  localparam logic [ALU_OPRN_WIDTH-1:0] OP_SHR = 6'h04;
  localparam logic [ALU_OPRN_WIDTH-1:0] OP_SHL = 6'h05;
  localparam logic [ALU_OPRN_WIDTH-1:0] OP_AND = 6'h06;
  localparam logic [ALU_OPRN_WIDTH-1:0] OP_OR  = 6'h07;
  localparam logic [ALU_OPRN_WIDTH-1:0] OP_NOR = 6'h08;
  localparam logic [ALU_OPRN_WIDTH-1:0] OP_SLT = 6'h09;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ERRDONE = 2'd2
  } state_e;

  function automatic logic op_is_legal(input logic [ALU_OPRN_WIDTH-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SLT);
  endfunction

  // Counter only ever holds settle-1, so n values need clog2(n) bits.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, status and ALU-side signals of the arbiter; slave is the
// arbiter, master is the surrounding control unit plus ALU.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic [1:0]                REQ;
  logic [DATA_WIDTH-1:0]     A0, B0, A1, B1;
  logic [ALU_OPRN_WIDTH-1:0] OPRN0, OPRN1;
  logic [1:0]                ACK, DONE;
  logic [DATA_WIDTH-1:0]     RESULT;
  logic                      ZERO, ERR, BUSY;
  logic [DATA_WIDTH-1:0]     ALU_A, ALU_B;
  logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN;
  logic [DATA_WIDTH-1:0]     ALU_Y;

  modport slave (
    input  REQ, A0, B0, OPRN0, A1, B1, OPRN1, ALU_Y,
    output ACK, DONE, RESULT, ZERO, ERR, BUSY, ALU_A, ALU_B, ALU_OPRN
  );

  modport master (
    output REQ, A0, B0, OPRN0, A1, B1, OPRN1, ALU_Y,
    input  ACK, DONE, RESULT, ZERO, ERR, BUSY, ALU_A, ALU_B, ALU_OPRN
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to
// the requester named by the priority pointer.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       pri_i,
  output logic       gnt_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    gnt_o   = (req_i == 2'b11) ? pri_i : req_i[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin scheduler for the shared combinational ALU: latches the
// granted request, waits the opcode's settle time, captures the result.
//
// state   | meaning
// IDLE    | no operation in flight; arbitrate REQ every cycle
// WAIT    | ALU inputs held, settle counter running down to zero
// ERRDONE | illegal opcode accepted; report ERR next cycle
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int SETTLE_CYCLES     = DEF_SETTLE_CYCLES,
  parameter int MUL_SETTLE_CYCLES = DEF_MUL_SETTLE_CYCLES
) (
  input  logic          CLK,
  input  logic          RST,
  alu_arbiter_if.slave  bus
);

  localparam int MAX_SETTLE = (MUL_SETTLE_CYCLES > SETTLE_CYCLES) ?
                              MUL_SETTLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W      = cnt_width(MAX_SETTLE);
  localparam logic [CNT_W-1:0] CNT_LD     = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MUL_LD = CNT_W'(MUL_SETTLE_CYCLES - 1);

  state_e                    state_q, state_d;
  logic                      pri_q, pri_d;
  logic                      gnt_q, gnt_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                ack_q, ack_d;
  logic [1:0]                done_q, done_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic                      zero_q, zero_d;
  logic                      err_q, err_d;
  logic [DATA_WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [ALU_OPRN_WIDTH-1:0] alu_op_q, alu_op_d;

  logic                      arb_gnt, arb_valid;
  logic [DATA_WIDTH-1:0]     sel_a, sel_b;
  logic [ALU_OPRN_WIDTH-1:0] sel_op;

  rr_arb2 u_rr_arb2 (
    .req_i   (bus.REQ),
    .pri_i   (pri_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  assign sel_a  = arb_gnt ? bus.A1    : bus.A0;
  assign sel_b  = arb_gnt ? bus.B1    : bus.B0;
  assign sel_op = arb_gnt ? bus.OPRN1 : bus.OPRN0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      pri_q    <= 1'b0;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      pri_q    <= pri_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pri_d    = pri_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    done_d   = '0;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d = arb_gnt;
          pri_d = ~arb_gnt;
          ack_d = 2'b01 << arb_gnt;
          // Illegal opcodes never reach the ALU registers.
          if (op_is_legal(sel_op)) begin
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            alu_op_d = sel_op;
            cnt_d    = (sel_op == OP_MUL) ? CNT_MUL_LD : CNT_LD;
            state_d  = WAIT;
          end else begin
            state_d  = ERRDONE;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d = bus.ALU_Y;
          zero_d   = ~|bus.ALU_Y;
          err_d    = 1'b0;
          done_d   = 2'b01 << gnt_q;
          state_d  = IDLE;
        end
      end
      ERRDONE: begin
        result_d = '0;
        zero_d   = 1'b0;
        err_d    = 1'b1;
        done_d   = 2'b01 << gnt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ACK      = ack_q;
  assign bus.DONE     = done_q;
  assign bus.RESULT   = result_q;
  assign bus.ZERO     = zero_q;
  assign bus.ERR      = err_q;
  assign bus.BUSY     = (state_q != IDLE);
  assign bus.ALU_A    = alu_a_q;
  assign bus.ALU_B    = alu_b_q;
  assign bus.ALU_OPRN = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int S_N = 2;
  localparam int S_M = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  alu_arbiter_if bus ();

  alu_arbiter #(.SETTLE_CYCLES(S_N), .MUL_SETTLE_CYCLES(S_M)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_SHR:  return a >> b[4:0];
      OP_SHL:  return a << b[4:0];
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.ALU_Y = alu_fn(bus.ALU_A, bus.ALU_B, bus.ALU_OPRN);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an op granted at edge e completes S edges later
  // and the port is free again one edge after completion.
  int          m_edge = 0, m_free = 0, m_done_edge = 0;
  logic        m_pend = 0, m_pri = 0, m_g = 0, m_pill = 0;
  logic [31:0] m_pres = 0;
  logic [1:0]  m_ack = 0, m_done = 0;
  logic [31:0] m_res = 0, m_a = 0, m_b = 0;
  logic        m_zero = 0, m_err = 0;
  logic [5:0]  m_op = 0;

  always @(posedge CLK or negedge RST) begin : model
    int          e, s;
    logic        g;
    logic [31:0] a, b;
    logic [5:0]  op;
    if (!RST) begin
      m_pend <= 0; m_free <= 0; m_pri <= 0; m_ack <= 0; m_done <= 0;
      m_res <= 0; m_zero <= 0; m_err <= 0; m_a <= 0; m_b <= 0; m_op <= 0;
    end else begin
      e = m_edge + 1;
      m_edge <= e;
      m_ack  <= 0;
      m_done <= 0;
      if (m_pend && e == m_done_edge) begin
        m_done <= 2'b01 << m_g;
        m_res  <= m_pres;
        m_err  <= m_pill;
        m_zero <= !m_pill && (m_pres == 0);
      end
      if (e >= m_free && bus.REQ != 2'b00) begin
        g  = (bus.REQ == 2'b11) ? m_pri : bus.REQ[1];
        a  = g ? bus.A1 : bus.A0;
        b  = g ? bus.B1 : bus.B0;
        op = g ? bus.OPRN1 : bus.OPRN0;
        m_pri  <= ~g;
        m_g    <= g;
        m_ack  <= 2'b01 << g;
        m_pend <= 1;
        if (op >= 1 && op <= 9) begin
          s = (op == 3) ? S_M : S_N;
          m_a <= a; m_b <= b; m_op <= op;
          m_pres <= alu_fn(a, b, op);
          m_pill <= 0;
        end else begin
          s = 1;
          m_pres <= 0;
          m_pill <= 1;
        end
        m_done_edge <= e + s;
        m_free      <= e + s + 1;
      end else if (m_pend && e == m_done_edge) begin
        m_pend <= 0;
      end
    end
  end

  always @(negedge CLK) begin
    chk("m_ack",    32'(bus.ACK),      32'(m_ack));
    chk("m_done",   32'(bus.DONE),     32'(m_done));
    chk("m_result", bus.RESULT,        m_res);
    chk("m_zero",   32'(bus.ZERO),     32'(m_zero));
    chk("m_err",    32'(bus.ERR),      32'(m_err));
    chk("m_busy",   32'(bus.BUSY),     32'(m_pend));
    chk("m_alu_a",  bus.ALU_A,         m_a);
    chk("m_alu_b",  bus.ALU_B,         m_b);
    chk("m_alu_op", 32'(bus.ALU_OPRN), 32'(m_op));
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
  } op_t;

  op_t        q0[$];
  op_t        q1[$];
  logic [1:0] req = 2'b00;

  task automatic push(input logic g, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] op);
    op_t o;
    o.a = a; o.b = b; o.op = op;
    if (g) q1.push_back(o);
    else   q0.push_back(o);
  endtask

  // One cycle of requester behaviour: drop/advance on ACK, hold otherwise,
  // start a new request with probability pct percent.
  task automatic step(input int pct);
    logic [1:0] ack;
    @(negedge CLK);
    ack = bus.ACK;
    if (req[0] && ack[0] && q0.size() > 0) q0.delete(0);
    if (req[1] && ack[1] && q1.size() > 0) q1.delete(0);
    if (!(req[0] && !ack[0])) begin
      if (q0.size() > 0 && int'($urandom_range(0, 99)) < pct) begin
        req[0] = 1'b1; bus.A0 = q0[0].a; bus.B0 = q0[0].b; bus.OPRN0 = q0[0].op;
      end else begin
        req[0] = 1'b0;
        if (pct < 100) begin bus.A0 = $urandom; bus.B0 = $urandom; bus.OPRN0 = 6'($urandom); end
      end
    end
    if (!(req[1] && !ack[1])) begin
      if (q1.size() > 0 && int'($urandom_range(0, 99)) < pct) begin
        req[1] = 1'b1; bus.A1 = q1[0].a; bus.B1 = q1[0].b; bus.OPRN1 = q1[0].op;
      end else begin
        req[1] = 1'b0;
        if (pct < 100) begin bus.A1 = $urandom; bus.B1 = $urandom; bus.OPRN1 = 6'($urandom); end
      end
    end
    bus.REQ = req;
  endtask

  task automatic run_one(input logic g, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op, input int s, input logic [31:0] eres,
                         input logic ezero, input logic eerr);
    push(g, a, b, op);
    step(100);
    step(100);
    chk("op_ack", 32'(bus.ACK), 32'(2'b01 << g));
    if (!eerr) begin
      chk("op_alu_a", bus.ALU_A, a);
      chk("op_alu_b", bus.ALU_B, b);
    end
    for (int k = 1; k < s; k++) begin
      step(100);
      chk("op_no_early_done", 32'(bus.DONE), 32'd0);
    end
    step(100);
    chk("op_done",   32'(bus.DONE), 32'(2'b01 << g));
    chk("op_result", bus.RESULT,    eres);
    chk("op_zero",   32'(bus.ZERO), 32'(ezero));
    chk("op_err",    32'(bus.ERR),  32'(eerr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before t=500000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic order[4];
    int   nack, nd, cyc, dut_dones;
    logic [5:0]  rop;
    logic [31:0] ra;

    bus.REQ = 0; bus.A0 = 0; bus.B0 = 0; bus.OPRN0 = 0;
    bus.A1 = 0; bus.B1 = 0; bus.OPRN1 = 0;
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(100);
      chk("idle_busy",   32'(bus.BUSY), 32'd0);
      chk("idle_done",   32'(bus.DONE), 32'd0);
      chk("idle_result", bus.RESULT,    32'd0);
      chk("idle_alu_a",  bus.ALU_A,     32'd0);
    end

    run_one(1'b0, 32'd5, 32'd7, OP_ADD, S_N, 32'd12, 1'b0, 1'b0);
    run_one(1'b1, 32'h10000, 32'h10000, OP_MUL, S_M, 32'd0, 1'b1, 1'b0);

    // Continuous contention: grants must alternate starting with port 0.
    push(1'b0, 32'd9, 32'd9, OP_SUB); push(1'b0, 32'd9, 32'd9, OP_SUB);
    push(1'b1, 32'd3, 32'd4, OP_SLT); push(1'b1, 32'd3, 32'd4, OP_SLT);
    step(100);
    nack = 0; nd = 0;
    for (int c = 0; c < 60 && nd < 4; c++) begin
      step(100);
      if (bus.ACK != 2'b00) begin
        if (nack < 4) order[nack] = bus.ACK[1];
        nack++;
      end
      if (bus.DONE == 2'b01) begin
        chk("cont_sub_result", bus.RESULT, 32'd0);
        chk("cont_sub_zero", 32'(bus.ZERO), 32'd1);
        nd++;
      end else if (bus.DONE == 2'b10) begin
        chk("cont_slt_result", bus.RESULT, 32'd1);
        chk("cont_slt_zero", 32'(bus.ZERO), 32'd0);
        nd++;
      end
    end
    chk("cont_dones", 32'(nd), 32'd4);
    chk("cont_acks", 32'(nack), 32'd4);
    if (nack >= 4) begin
      chk("cont_grant0", 32'(order[0]), 32'd0);
      chk("cont_grant1", 32'(order[1]), 32'd1);
      chk("cont_grant2", 32'(order[2]), 32'd0);
      chk("cont_grant3", 32'(order[3]), 32'd1);
    end

    // Reset in the middle of a settle window discards the operation.
    push(1'b0, 32'd1, 32'd2, OP_ADD);
    step(100);
    step(100);
    chk("rst_pre_ack", 32'(bus.ACK), 32'd1);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("rst_busy",   32'(bus.BUSY),     32'd0);
    chk("rst_result", bus.RESULT,        32'd0);
    chk("rst_alu_a",  bus.ALU_A,         32'd0);
    chk("rst_alu_b",  bus.ALU_B,         32'd0);
    chk("rst_alu_op", 32'(bus.ALU_OPRN), 32'd0);
    chk("rst_flags",  {27'd0, bus.ACK, bus.DONE, bus.ZERO} | 32'(bus.ERR), 32'd0);
    step(100);
    step(100);
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(100);
      chk("rst_no_done", 32'(bus.DONE), 32'd0);
    end
    run_one(1'b0, 32'd20, 32'd22, OP_ADD, S_N, 32'd42, 1'b0, 1'b0);

    run_one(1'b0, 32'h123, 32'h456, 6'h0B, 1, 32'd0, 1'b0, 1'b1);
    chk("ill_alu_a",  bus.ALU_A,         32'd20);
    chk("ill_alu_b",  bus.ALU_B,         32'd22);
    chk("ill_alu_op", 32'(bus.ALU_OPRN), 32'(OP_ADD));

    // Randomized traffic, including illegal opcodes and zero-result operands.
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 9) < 2)
          rop = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom_range(10, 63));
        else
          rop = 6'($urandom_range(1, 9));
        ra = $urandom;
        push(g[0], ra, ($urandom_range(0, 3) == 0) ? ra : $urandom, rop);
      end
    end
    cyc = 0; dut_dones = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req != 2'b00 || m_pend) && cyc < 6000) begin
      step(60);
      dut_dones += int'(bus.DONE[0]) + int'(bus.DONE[1]);
      cyc++;
    end
    chk("random_drain", 32'(cyc < 6000), 32'd1);
    chk("random_done_count", 32'(dut_dones), 32'd80);
    repeat (5) step(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
